// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states, layer-memory selects and 3x3 tap geometry
// used by conv_sched and conv_addr_gen.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_CWR,
    ST_POOL,
    ST_PWR,
    ST_DONE
  } state_e;

  localparam logic [2:0] CSEL_IDLE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam int TAPS   = 9;
  localparam int POOL_K = 4;

  localparam logic signed [1:0] OFF_NEG  = -2'sd1;
  localparam logic signed [1:0] OFF_ZERO = 2'sd0;
  localparam logic signed [1:0] OFF_POS  = 2'sd1;

  // Row offset of tap t: t/3 - 1
  function automatic logic signed [1:0] tap_dy(input logic [3:0] t);
    if (t < 4'd3)      tap_dy = OFF_NEG;
    else if (t < 4'd6) tap_dy = OFF_ZERO;
    else               tap_dy = OFF_POS;
  endfunction

  // Column offset of tap t: t%3 - 1
  function automatic logic signed [1:0] tap_dx(input logic [3:0] t);
    case (t)
      4'd0, 4'd3, 4'd6: tap_dx = OFF_NEG;
      4'd1, 4'd4, 4'd7: tap_dx = OFF_ZERO;
      default:          tap_dx = OFF_POS;
    endcase
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: maps pixel (row, col) and tap index to an image address,
// flagging taps that fall in the zero-padding border.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic [$clog2(IMG_H)-1:0] row_i,
  input  logic [$clog2(IMG_W)-1:0] col_i,
  input  logic [3:0]               tap_i,
  output logic [ADDR_W-1:0]        addr_o,
  output logic                     pad_o
);

  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(IMG_W);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ROW_LIM = ADDR_W'(IMG_H);
  localparam logic [ADDR_W-1:0] COL_LIM = ADDR_W'(IMG_W);

  logic signed [1:0] dy;
  logic signed [1:0] dx;
  logic [AW1-1:0]    rr;
  logic [AW1-1:0]    cc;
  logic              row_out;
  logic              col_out;

  assign dy = tap_dy(tap_i);
  assign dx = tap_dx(tap_i);

  // One spare bit holds the sign so -1 and IMG_H are both caught before truncation
  assign rr = {{(AW1-RW){1'b0}}, row_i} + {{(AW1-2){dy[1]}}, dy};
  assign cc = {{(AW1-CW){1'b0}}, col_i} + {{(AW1-2){dx[1]}}, dx};

  assign row_out = rr[AW1-1] | (rr[AW1-2:0] >= ROW_LIM);
  assign col_out = cc[AW1-1] | (cc[AW1-2:0] >= COL_LIM);
  assign pad_o   = row_out | col_out;

  assign addr_o = pad_o ? '0 : ({rr[ADDR_W-CW-1:0], {CW{1'b0}}} + cc[ADDR_W-1:0]);

endmodule

// File: rtl/conv_sched.sv
// conv_sched: sequencer for 3x3 padded conv (layer 0) and 2x2 max-pool (layer 1).
// Pool pass is built only when CONV_SCHED_POOL_EN is defined.
module conv_sched
  import conv_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [2:0]        csel,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [3:0]        mac_tap,
  output logic              mac_pad,
  output logic              pool_clr,
  output logic              pool_en
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  state_e        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [3:0]    t_q, t_d;
  logic          last_pix;

`ifdef CONV_SCHED_POOL_EN
  logic [RW-2:0] pr_q, pr_d;
  logic [CW-2:0] pc_q, pc_d;
  logic [1:0]    pk_q, pk_d;
  logic          last_out;
  logic          pclr_d;
  logic          pool_clr_q, pool_en_q;
`endif

  logic [ADDR_W-1:0] ag_addr;
  logic              ag_pad;

  logic              busy_d, issue_d, pad_d, mclr_d, crd_d, cwr_d;
  logic [ADDR_W-1:0] iaddr_d, caddr_rd_d, caddr_wr_d;
  logic [3:0]        tap_d;
  logic [2:0]        csel_d;

  logic              busy_q, issue_q, pad_q, mac_clr_q, crd_q, cwr_q;
  logic [ADDR_W-1:0] iaddr_q, caddr_rd_q, caddr_wr_q;
  logic [3:0]        tap_q, mac_tap_q;
  logic [2:0]        csel_q;
  logic              mac_en_q, mac_pad_q;

  assign last_pix = (&r_q) & (&c_q);

  // Address generator looks at the next-cycle counters so iaddr can be registered
  conv_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .row_i (r_d),
    .col_i (c_d),
    .tap_i (t_d),
    .addr_o(ag_addr),
    .pad_o (ag_pad)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      t_q     <= t_d;
    end
  end

`ifdef CONV_SCHED_POOL_EN
  assign last_out = (&pr_q) & (&pc_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pr_q <= '0;
      pc_q <= '0;
      pk_q <= '0;
    end else begin
      pr_q <= pr_d;
      pc_q <= pc_d;
      pk_q <= pk_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    t_d     = t_q;
`ifdef CONV_SCHED_POOL_EN
    pr_d    = pr_q;
    pc_d    = pc_q;
    pk_d    = pk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          state_d = ST_CONV;
          r_d     = '0;
          c_d     = '0;
          t_d     = '0;
        end
      end
      // t runs 0..8 issuing taps, then t=9 is the drain cycle for the last mac_en
      ST_CONV: begin
        if (t_q == 4'(TAPS)) state_d = ST_CWR;
        else                 t_d     = t_q + 4'd1;
      end
      ST_CWR: begin
        t_d = '0;
        c_d = c_q + 1'b1;
        if (&c_q) r_d = r_q + 1'b1;
        if (last_pix) begin
`ifdef CONV_SCHED_POOL_EN
          state_d = ST_POOL;
          pr_d    = '0;
          pc_d    = '0;
          pk_d    = '0;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_CONV;
        end
      end
`ifdef CONV_SCHED_POOL_EN
      ST_POOL: begin
        if (pk_q == 2'(POOL_K - 1)) begin
          state_d = ST_PWR;
          pk_d    = '0;
        end else begin
          pk_d = pk_q + 2'd1;
        end
      end
      // pk=0 drains the last pool_en, pk=1 writes the pooled value
      ST_PWR: begin
        if (pk_q == 2'd0) begin
          pk_d = 2'd1;
        end else begin
          pk_d = '0;
          pc_d = pc_q + 1'b1;
          if (&pc_q) pr_d = pr_q + 1'b1;
          state_d = last_out ? ST_DONE : ST_POOL;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    issue_d    = 1'b0;
    iaddr_d    = '0;
    pad_d      = 1'b0;
    tap_d      = '0;
    mclr_d     = 1'b0;
    crd_d      = 1'b0;
    caddr_rd_d = '0;
    cwr_d      = 1'b0;
    caddr_wr_d = '0;
    csel_d     = CSEL_IDLE;
`ifdef CONV_SCHED_POOL_EN
    pclr_d     = 1'b0;
`endif
    case (state_d)
      ST_CONV: begin
        if (t_d < 4'(TAPS)) begin
          issue_d = 1'b1;
          iaddr_d = ag_addr;
          pad_d   = ag_pad;
          tap_d   = t_d;
          mclr_d  = (t_d == 4'd0);
        end
      end
      ST_CWR: begin
        cwr_d      = 1'b1;
        csel_d     = CSEL_L0;
        caddr_wr_d = {r_d, c_d};
      end
`ifdef CONV_SCHED_POOL_EN
      // Window element k sits at row 2pr + k/2, column 2pc + k%2
      ST_POOL: begin
        crd_d      = 1'b1;
        csel_d     = CSEL_L0;
        caddr_rd_d = {pr_d, pk_d[1], pc_d, pk_d[0]};
        pclr_d     = (pk_d == 2'd0);
      end
      ST_PWR: begin
        if (pk_d == 2'd1) begin
          cwr_d      = 1'b1;
          csel_d     = CSEL_L1;
          caddr_wr_d = {2'b00, pr_d, pc_d};
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= 1'b0;
      issue_q    <= 1'b0;
      iaddr_q    <= '0;
      pad_q      <= 1'b0;
      tap_q      <= '0;
      mac_clr_q  <= 1'b0;
      mac_en_q   <= 1'b0;
      mac_tap_q  <= '0;
      mac_pad_q  <= 1'b0;
      crd_q      <= 1'b0;
      caddr_rd_q <= '0;
      cwr_q      <= 1'b0;
      caddr_wr_q <= '0;
      csel_q     <= CSEL_IDLE;
    end else begin
      busy_q     <= busy_d;
      issue_q    <= issue_d;
      iaddr_q    <= iaddr_d;
      pad_q      <= pad_d;
      tap_q      <= tap_d;
      mac_clr_q  <= mclr_d;
      mac_en_q   <= issue_q;
      mac_tap_q  <= tap_q;
      mac_pad_q  <= pad_q;
      crd_q      <= crd_d;
      caddr_rd_q <= caddr_rd_d;
      cwr_q      <= cwr_d;
      caddr_wr_q <= caddr_wr_d;
      csel_q     <= csel_d;
    end
  end

`ifdef CONV_SCHED_POOL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pool_clr_q <= 1'b0;
      pool_en_q  <= 1'b0;
    end else begin
      pool_clr_q <= pclr_d;
      pool_en_q  <= crd_q;
    end
  end

  assign pool_clr = pool_clr_q;
  assign pool_en  = pool_en_q;
`else
  assign pool_clr = 1'b0;
  assign pool_en  = 1'b0;
`endif

  assign busy     = busy_q;
  assign iaddr    = iaddr_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_rd_q;
  assign cwr      = cwr_q;
  assign caddr_wr = caddr_wr_q;
  assign csel     = csel_q;
  assign mac_clr  = mac_clr_q;
  assign mac_en   = mac_en_q;
  assign mac_tap  = mac_tap_q;
  assign mac_pad  = mac_pad_q;

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: table-driven check of conv_sched output timing, plus reset
// sequences; expectations follow CONV_SCHED_POOL_EN when it is defined.
module tb_conv_sched;

  typedef struct packed {
    logic        busy;
    logic [11:0] iaddr;
    logic        mac_clr;
    logic        mac_en;
    logic [3:0]  mac_tap;
    logic        mac_pad;
    logic        crd;
    logic [11:0] caddr_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [2:0]  csel;
    logic        pool_clr;
    logic        pool_en;
  } outs_t;

  typedef struct packed {
    int    cyc;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        busy, crd, cwr, mac_clr, mac_en, mac_pad, pool_clr, pool_en;
  logic [11:0] iaddr, caddr_rd, caddr_wr;
  logic [2:0]  csel;
  logic [3:0]  mac_tap;

  outs_t act_w;
  vec_t  tbl[$];
  int    cyc;
  int    checks = 0;
  int    errors = 0;
  int    viol   = 0;

  conv_sched dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .busy    (busy),
    .iaddr   (iaddr),
    .crd     (crd),
    .caddr_rd(caddr_rd),
    .cwr     (cwr),
    .caddr_wr(caddr_wr),
    .csel    (csel),
    .mac_clr (mac_clr),
    .mac_en  (mac_en),
    .mac_tap (mac_tap),
    .mac_pad (mac_pad),
    .pool_clr(pool_clr),
    .pool_en (pool_en)
  );

  always #5 clk = ~clk;

  always_comb begin
    act_w          = '0;
    act_w.busy     = busy;
    act_w.iaddr    = iaddr;
    act_w.mac_clr  = mac_clr;
    act_w.mac_en   = mac_en;
    act_w.mac_tap  = mac_tap;
    act_w.mac_pad  = mac_pad;
    act_w.crd      = crd;
    act_w.caddr_rd = caddr_rd;
    act_w.cwr      = cwr;
    act_w.caddr_wr = caddr_wr;
    act_w.csel     = csel;
    act_w.pool_clr = pool_clr;
    act_w.pool_en  = pool_en;
  end

  // Strobe clashes and, without pooling, any layer-1 select are illegal
  always @(negedge clk) begin
    if (reset) begin
      if (crd && cwr) viol++;
`ifndef CONV_SCHED_POOL_EN
      if (csel == 3'b011) viol++;
`endif
    end
  end

  function automatic outs_t o_conv(int ia, bit clr, bit en, int tap, bit pad);
    outs_t o = '0;
    o.busy = 1'b1; o.iaddr = 12'(ia); o.mac_clr = clr;
    o.mac_en = en; o.mac_tap = 4'(tap); o.mac_pad = pad;
    return o;
  endfunction

  function automatic outs_t o_wr(int a, int sel);
    outs_t o = '0;
    o.busy = 1'b1; o.cwr = 1'b1; o.caddr_wr = 12'(a); o.csel = 3'(sel);
    return o;
  endfunction

  function automatic outs_t o_rd(int a, bit clr, bit en);
    outs_t o = '0;
    o.busy = 1'b1; o.crd = 1'b1; o.caddr_rd = 12'(a); o.csel = 3'b001;
    o.pool_clr = clr; o.pool_en = en;
    return o;
  endfunction

  function automatic outs_t o_busy(bit b, bit pen);
    outs_t o = '0;
    o.busy = b; o.pool_en = pen;
    return o;
  endfunction

  function automatic void add(int c, outs_t o);
    vec_t v;
    v.cyc = c;
    v.exp = o;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1 ready = (cyc >= 29 && cyc <= 31);
    @(negedge clk);
  endtask

  task automatic chk(string nm, outs_t exp);
    checks++;
    if (act_w !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act_w, exp);
    end else begin
      $display("check %s cyc=%0d ok", nm, cyc);
    end
  endtask

  task automatic chk_int(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end else begin
      $display("check %s ok", nm);
    end
  endtask

  task automatic run_table(int lim);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].cyc <= lim) begin
        while (cyc < tbl[i].cyc) tick();
        chk($sformatf("vec%0d", i), tbl[i].exp);
      end
    end
  endtask

  initial begin
    // Pixel (0,0) and (0,1)
    add(1,  o_conv(0, 1, 0, 0, 0));
    add(2,  o_conv(0, 0, 1, 0, 1));
    add(3,  o_conv(0, 0, 1, 1, 1));
    add(4,  o_conv(0, 0, 1, 2, 1));
    add(5,  o_conv(0, 0, 1, 3, 1));
    add(6,  o_conv(1, 0, 1, 4, 0));
    add(7,  o_conv(0, 0, 1, 5, 0));
    add(8,  o_conv(64, 0, 1, 6, 1));
    add(9,  o_conv(65, 0, 1, 7, 0));
    add(10, o_conv(0, 0, 1, 8, 0));
    add(11, o_wr(0, 1));
    add(12, o_conv(0, 1, 0, 0, 0));
    add(17, o_conv(2, 0, 1, 4, 0));
    add(22, o_wr(1, 1));
    // ready pulsed during cycles 29..31 must not disturb the sequence
    add(33, o_wr(2, 1));
    add(34, o_conv(0, 1, 0, 0, 0));
    // Pixel (1,0): left border padding
    add(705, o_conv(0, 1, 0, 0, 0));
    add(707, o_conv(1, 0, 1, 1, 0));
    add(709, o_conv(64, 0, 1, 3, 1));
    // Pixel (63,63)
    add(45046, o_conv(4030, 1, 0, 0, 0));
    add(45050, o_conv(4095, 0, 1, 3, 0));
    add(45054, o_conv(0, 0, 1, 7, 1));
    add(45055, o_conv(0, 0, 1, 8, 1));
    add(45056, o_wr(4095, 1));
`ifdef CONV_SCHED_POOL_EN
    add(45057, o_rd(0, 1, 0));
    add(45058, o_rd(1, 0, 1));
    add(45059, o_rd(64, 0, 1));
    add(45060, o_rd(65, 0, 1));
    add(45061, o_busy(1, 1));
    add(45062, o_wr(0, 3));
    add(45063, o_rd(2, 1, 0));
    add(51195, o_rd(4030, 1, 0));
    add(51196, o_rd(4031, 0, 1));
    add(51197, o_rd(4094, 0, 1));
    add(51198, o_rd(4095, 0, 1));
    add(51199, o_busy(1, 1));
    add(51200, o_wr(1023, 3));
    add(51201, o_busy(1, 0));
    add(51202, o_busy(0, 0));
    add(51205, o_busy(0, 0));
`else
    add(45057, o_busy(1, 0));
    add(45058, o_busy(0, 0));
    add(45061, o_busy(0, 0));
`endif

    // Reset held with ready high: everything stays at zero
    reset = 1'b0;
    ready = 1'b1;
    cyc   = 0;
    repeat (3) @(negedge clk);
    chk("reset_hold", '0);
    reset = 1'b1;
    #1 chk("release_cycle0", '0);

    run_table(709);
    while (cyc < 20000) tick();
    chk_int("busy_before_reset", int'(busy), 1);

    // Mid-run reset clears outputs without waiting for a clock edge
    #2 reset = 1'b0;
    #1 chk("async_reset", '0);
    @(negedge clk);
    reset = 1'b1;
    ready = 1'b1;
    cyc   = 0;
    #1 chk("restart_cycle0", '0);

    run_table(60000);
    chk_int("strobe_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
